keyboard_scancode_decoder: RTL and testbench
============================================

Name: keyboard_scancode_decoder

Overview:
Sits directly downstream of the PS/2 byte receiver. It consumes its one-cycle byte strobe and 8-bit scancode (Set 2) and folds the E0, F0 and E1 prefix sequences into single key events, each marked make/break and extended. Events are buffered in a small FIFO that the keyboard register/IRQ block drains with a valid/pop handshake. It also drops keyboard protocol replies and fake-shift codes, and recovers from truncated prefix sequences with a timeout.

Parameters:
P_FIFO_DEPTH, 16, event FIFO entries; power of two, at least 2.
P_FIFO_DEPTH_N, 4, log2(P_FIFO_DEPTH).
P_TIMEOUT, 100000, iCLOCK cycles of prefix inactivity (2 ms at 50 MHz) before the decoder abandons a partial sequence.

Ports:
iCLOCK  in  1  clock
inRESET  in  1  asynchronous reset, active-low
iRESET_SYNC  in  1  synchronous reset, active-high; same effect as inRESET
iPS2MOD_REQ  in  1  one-cycle strobe, a received byte is present
iPS2MOD_DATA  in  8  received scancode byte, valid with iPS2MOD_REQ
oEVENT_VALID  out  1  FIFO not empty
oEVENT_DATA  out  10  head event: [9] break, [8] extended, [7:0] code
iEVENT_POP  in  1  consume head event; ignored when oEVENT_VALID=0
oEVENT_COUNT  out  P_FIFO_DEPTH_N+1  FIFO occupancy
oOVERFLOW  out  1  sticky: an event was dropped because the FIFO was full
iOVERFLOW_CLEAR  in  1  clears oOVERFLOW

Behaviour:
- Reset (async or sync): state IDLE, FIFO empty, timeout counter 0. Outputs: oEVENT_VALID=0, oEVENT_DATA=0, oEVENT_COUNT=0, oOVERFLOW=0.
- Byte handling happens only in cycles with iPS2MOD_REQ=1. Other cycles change only the timeout counter and the FIFO pop.
- Filtered bytes: 0xFA, 0xFE, 0xAA, 0xEE, 0x00 and 0xFF are dropped and leave the state unchanged. The one exception is inside PAUSE, where every byte is counted.
- IDLE:
  - E0 goes to EXT.
  - F0 goes to BRK.
  - E1 goes to PAUSE with skip counter 0.
  - Any other code c pushes {0,0,c}.
- EXT:
  - F0 goes to EXTBRK.
  - E0 stays in EXT.
  - E1 goes to PAUSE.
  - Code c pushes {0,1,c} and returns to IDLE. If c is 0x12 or 0x59 (fake shift), nothing is pushed and the state returns to IDLE.
- BRK:
  - E0 goes to EXTBRK.
  - F0 stays in BRK.
  - Code c pushes {1,0,c} and returns to IDLE.
- EXTBRK:
  - Code c pushes {1,1,c} and returns to IDLE. Fake-shift codes 0x12 and 0x59 push nothing and return to IDLE.
  - Prefix bytes are absorbed and the state stays EXTBRK.
- PAUSE: counts 7 further bytes of any value. On the 7th byte it pushes {0,1,0x77} and returns to IDLE.
- Timeout: in any state other than IDLE, the counter increments every cycle without a REQ and resets to 0 on each REQ. When it reaches P_TIMEOUT-1, the state goes to IDLE with no event and the counter clears.
- Latency: an event is written at the rising edge that samples the final REQ. oEVENT_VALID is high the next cycle (1-cycle latency).
- FIFO:
  - Show-ahead: oEVENT_DATA is the head entry, and is 0 when empty.
  - Pop when iEVENT_POP && !empty.
  - Push when an event is generated && (!full || pop in the same cycle). When full with a simultaneous pop, the push is accepted and the count is unchanged.
  - Push when full without a pop: the event is dropped and oOVERFLOW is set the next cycle.
  - Read and write pointers are P_FIFO_DEPTH_N bits and wrap naturally.
  - Simultaneous push and pop when empty: the push lands and the pop is ignored.
- oOVERFLOW: when set and clear happen in the same cycle, set wins.
- A reset during a partial sequence discards the partial sequence and all buffered events.

Decomposition:
- Package keyboard_pkg holds:
  - Scancode constants: KB_SC_EXT=E0, KB_SC_BRK=F0, KB_SC_PAUSE=E1, KB_SC_ACK=FA, KB_SC_RESEND=FE, KB_SC_BATOK=AA, KB_SC_ECHO=EE, KB_SC_ERR0=00, KB_SC_ERR1=FF, KB_SC_LSHIFT=12, KB_SC_RSHIFT=59.
  - The decoder state enum (IDLE/EXT/BRK/EXTBRK/PAUSE).
  - The 10-bit event field positions.
- Sub-module keyboard_event_fifo: a parameterised synchronous show-ahead FIFO with count, full and empty outputs.
- The decoder FSM, timeout counter and overflow flag live in the top module.

Test Plan:
1. REQ with 0x1C, then no pop -> next cycle oEVENT_VALID=1, oEVENT_DATA=0x01C, oEVENT_COUNT=1. Pop -> VALID=0, DATA=0.
2. Bytes F0,1C then E0,F0,75 then E0,12 -> exactly two events, 0x21C then 0x375; the fake shift is dropped.
3. Bytes E1,14,77,E1,F0,14,F0,77 -> exactly one event, 0x177; state returns to IDLE. A following 0x1C yields 0x01C.
4. E0, then P_TIMEOUT idle cycles, then 0x1C -> event 0x01C (not extended). The same sequence with the gap at P_TIMEOUT-2 -> 0x11C.
5. 17 plain codes with no pops -> count=16, oOVERFLOW=1; popping 16 events returns the first 16 codes in order. iOVERFLOW_CLEAR -> 0. Full FIFO with push and pop in the same cycle -> count stays 16 and OVERFLOW stays 0.
6. Assert inRESET or iRESET_SYNC after F0 with 3 events buffered -> all outputs 0. A subsequent 0x1C -> 0x01C (make, not break). Bytes FA, AA and FE produce no events.

Source files
------------

// File: rtl/keyboard_pkg.sv
// Shared scancode constants, decoder state encoding and key-event field layout
// for the PS/2 Set 2 scancode decoder.
package keyboard_pkg;

  localparam logic [7:0] KB_SC_EXT    = 8'hE0;
  localparam logic [7:0] KB_SC_BRK    = 8'hF0;
  localparam logic [7:0] KB_SC_PAUSE  = 8'hE1;
  localparam logic [7:0] KB_SC_ACK    = 8'hFA;
  localparam logic [7:0] KB_SC_RESEND = 8'hFE;
  localparam logic [7:0] KB_SC_BATOK  = 8'hAA;
  localparam logic [7:0] KB_SC_ECHO   = 8'hEE;
  localparam logic [7:0] KB_SC_ERR0   = 8'h00;
  localparam logic [7:0] KB_SC_ERR1   = 8'hFF;
  localparam logic [7:0] KB_SC_LSHIFT = 8'h12;
  localparam logic [7:0] KB_SC_RSHIFT = 8'h59;

  // Pause is E1 followed by this many bytes whose values are irrelevant.
  localparam int KB_PAUSE_BYTES = 7;
  localparam logic [7:0] KB_SC_PAUSE_CODE = 8'h77;

  localparam int KB_EV_WIDTH     = 10;
  localparam int KB_EV_BREAK_BIT = 9;
  localparam int KB_EV_EXT_BIT   = 8;
  localparam int KB_EV_CODE_MSB  = 7;
  localparam int KB_EV_CODE_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_PAUSE
  } kb_state_e;

  function automatic logic kb_is_filtered(input logic [7:0] code);
    return (code == KB_SC_ACK)   || (code == KB_SC_RESEND) ||
           (code == KB_SC_BATOK) || (code == KB_SC_ECHO)   ||
           (code == KB_SC_ERR0)  || (code == KB_SC_ERR1);
  endfunction

  function automatic logic kb_is_fake_shift(input logic [7:0] code);
    return (code == KB_SC_LSHIFT) || (code == KB_SC_RSHIFT);
  endfunction

  function automatic logic [KB_EV_WIDTH-1:0] kb_make_event(input logic       brk,
                                                          input logic       ext,
                                                          input logic [7:0] code);
    logic [KB_EV_WIDTH-1:0] ev;
    ev = '0;
    ev[KB_EV_BREAK_BIT] = brk;
    ev[KB_EV_EXT_BIT]   = ext;
    ev[KB_EV_CODE_MSB:KB_EV_CODE_LSB] = code;
    return ev;
  endfunction

endpackage

// File: rtl/keyboard_event_fifo.sv
// Synchronous show-ahead FIFO for decoded key events; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module keyboard_event_fifo #(
  parameter int P_WIDTH   = 10,
  parameter int P_DEPTH   = 16,
  parameter int P_DEPTH_N = 4
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               sync_reset_i,
  input  logic               push_i,
  input  logic [P_WIDTH-1:0] data_i,
  input  logic               pop_i,
  output logic [P_WIDTH-1:0] data_o,
  output logic [P_DEPTH_N:0] count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam logic [P_DEPTH_N:0] LP_FULL_COUNT = (P_DEPTH_N+1)'(P_DEPTH);

  logic [P_WIDTH-1:0]   mem_q [P_DEPTH];
  logic [P_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
  logic [P_DEPTH_N:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == LP_FULL_COUNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (sync_reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: data_o is masked to zero while the FIFO is empty.
  always_ff @(posedge iCLOCK) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/keyboard_scancode_decoder.sv
// Folds PS/2 Set 2 prefix sequences (E0/F0/E1) into single make/break key events
// and queues them for the register/IRQ block.
module keyboard_scancode_decoder
  import keyboard_pkg::*;
#(
  parameter int P_FIFO_DEPTH   = 16,
  parameter int P_FIFO_DEPTH_N = 4,
  parameter int P_TIMEOUT      = 100000
) (
  input  logic                        iCLOCK,
  input  logic                        inRESET,
  input  logic                        iRESET_SYNC,
  input  logic                        iPS2MOD_REQ,
  input  logic [7:0]                  iPS2MOD_DATA,
  output logic                        oEVENT_VALID,
  output logic [KB_EV_WIDTH-1:0]      oEVENT_DATA,
  input  logic                        iEVENT_POP,
  output logic [P_FIFO_DEPTH_N:0]     oEVENT_COUNT,
  output logic                        oOVERFLOW,
  input  logic                        iOVERFLOW_CLEAR
);

  localparam int               LP_TMO_W    = $clog2(P_TIMEOUT + 1);
  localparam logic [LP_TMO_W-1:0] LP_TMO_LAST = LP_TMO_W'(P_TIMEOUT - 1);
  localparam logic [2:0]       LP_SKIP_LAST = 3'(KB_PAUSE_BYTES - 1);

  kb_state_e               state_q, state_d;
  logic [2:0]              skip_q, skip_d;
  logic [LP_TMO_W-1:0]     tmo_q, tmo_d;
  logic                    ovf_q, ovf_d;
  logic                    ev_push;
  logic [KB_EV_WIDTH-1:0]  ev_data;
  logic                    fifo_full, fifo_empty;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    ev_push = 1'b0;
    ev_data = '0;
    if (iPS2MOD_REQ) begin
      tmo_d = '0;
      if (state_q == ST_PAUSE) begin
        // Pause bytes are counted regardless of value, protocol replies included.
        if (skip_q == LP_SKIP_LAST) begin
          ev_push = 1'b1;
          ev_data = kb_make_event(1'b0, 1'b1, KB_SC_PAUSE_CODE);
          state_d = ST_IDLE;
          skip_d  = '0;
        end else begin
          skip_d = skip_q + 1'b1;
        end
      end else if (!kb_is_filtered(iPS2MOD_DATA)) begin
        case (state_q)
          ST_IDLE: begin
            case (iPS2MOD_DATA)
              KB_SC_EXT:   state_d = ST_EXT;
              KB_SC_BRK:   state_d = ST_BRK;
              KB_SC_PAUSE: begin state_d = ST_PAUSE; skip_d = '0; end
              default: begin
                ev_push = 1'b1;
                ev_data = kb_make_event(1'b0, 1'b0, iPS2MOD_DATA);
              end
            endcase
          end
          ST_EXT: begin
            case (iPS2MOD_DATA)
              KB_SC_EXT:   state_d = ST_EXT;
              KB_SC_BRK:   state_d = ST_EXTBRK;
              KB_SC_PAUSE: begin state_d = ST_PAUSE; skip_d = '0; end
              default: begin
                ev_push = !kb_is_fake_shift(iPS2MOD_DATA);
                ev_data = kb_make_event(1'b0, 1'b1, iPS2MOD_DATA);
                state_d = ST_IDLE;
              end
            endcase
          end
          ST_BRK: begin
            case (iPS2MOD_DATA)
              KB_SC_EXT:   state_d = ST_EXTBRK;
              KB_SC_BRK:   state_d = ST_BRK;
              KB_SC_PAUSE: begin state_d = ST_PAUSE; skip_d = '0; end
              default: begin
                ev_push = 1'b1;
                ev_data = kb_make_event(1'b1, 1'b0, iPS2MOD_DATA);
                state_d = ST_IDLE;
              end
            endcase
          end
          ST_EXTBRK: begin
            case (iPS2MOD_DATA)
              KB_SC_EXT, KB_SC_BRK, KB_SC_PAUSE: state_d = ST_EXTBRK;
              default: begin
                ev_push = !kb_is_fake_shift(iPS2MOD_DATA);
                ev_data = kb_make_event(1'b1, 1'b1, iPS2MOD_DATA);
                state_d = ST_IDLE;
              end
            endcase
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      // A stalled partial sequence is abandoned silently.
      if (tmo_q == LP_TMO_LAST) begin
        state_d = ST_IDLE;
        skip_d  = '0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (iOVERFLOW_CLEAR) ovf_d = 1'b0;
    if (ev_push && fifo_full && !iEVENT_POP) ovf_d = 1'b1;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (iRESET_SYNC) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
      ovf_q   <= ovf_d;
    end
  end

  keyboard_event_fifo #(
    .P_WIDTH   (KB_EV_WIDTH),
    .P_DEPTH   (P_FIFO_DEPTH),
    .P_DEPTH_N (P_FIFO_DEPTH_N)
  ) u_fifo (
    .iCLOCK       (iCLOCK),
    .inRESET      (inRESET),
    .sync_reset_i (iRESET_SYNC),
    .push_i       (ev_push),
    .data_i       (ev_data),
    .pop_i        (iEVENT_POP),
    .data_o       (oEVENT_DATA),
    .count_o      (oEVENT_COUNT),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  assign oEVENT_VALID = !fifo_empty;
  assign oOVERFLOW    = ovf_q;

endmodule

// File: tb/tb_keyboard_scancode_decoder.sv
// Self-checking bench for keyboard_scancode_decoder: directed scenarios plus
// randomized key sequences checked against a sequence-level event model.
module tb_keyboard_scancode_decoder;

  localparam int TMO     = 50;
  localparam int DEPTH   = 16;
  localparam int DEPTH_N = 4;

  logic             iCLOCK = 1'b0;
  logic             inRESET;
  logic             iRESET_SYNC;
  logic             iPS2MOD_REQ;
  logic [7:0]       iPS2MOD_DATA;
  logic             oEVENT_VALID;
  logic [9:0]       oEVENT_DATA;
  logic             iEVENT_POP;
  logic [DEPTH_N:0] oEVENT_COUNT;
  logic             oOVERFLOW;
  logic             iOVERFLOW_CLEAR;

  int errors = 0;
  int checks = 0;

  keyboard_scancode_decoder #(
    .P_FIFO_DEPTH   (DEPTH),
    .P_FIFO_DEPTH_N (DEPTH_N),
    .P_TIMEOUT      (TMO)
  ) dut (
    .iCLOCK          (iCLOCK),
    .inRESET         (inRESET),
    .iRESET_SYNC     (iRESET_SYNC),
    .iPS2MOD_REQ     (iPS2MOD_REQ),
    .iPS2MOD_DATA    (iPS2MOD_DATA),
    .oEVENT_VALID    (oEVENT_VALID),
    .oEVENT_DATA     (oEVENT_DATA),
    .iEVENT_POP      (iEVENT_POP),
    .oEVENT_COUNT    (oEVENT_COUNT),
    .oOVERFLOW       (oOVERFLOW),
    .iOVERFLOW_CLEAR (iOVERFLOW_CLEAR)
  );

  always #5 iCLOCK = ~iCLOCK;

  // All drivers change on the falling edge, so the DUT samples stable inputs.
  task automatic idle(input int n);
    repeat (n) @(negedge iCLOCK);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    iPS2MOD_REQ  = 1'b1;
    iPS2MOD_DATA = b;
    @(negedge iCLOCK);
    iPS2MOD_REQ  = 1'b0;
    iPS2MOD_DATA = 8'h00;
  endtask

  task automatic popOne;
    iEVENT_POP = 1'b1;
    @(negedge iCLOCK);
    iEVENT_POP = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge iCLOCK);
    inRESET = 1'b0;
    idle(2);
    inRESET = 1'b1;
    idle(1);
    checks++; if (oEVENT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", oEVENT_VALID); end
    checks++; if (oEVENT_DATA !== 10'h000) begin errors++; $display("[TB] FAIL reset_data: got %h want 000", oEVENT_DATA); end
    checks++; if (oEVENT_COUNT !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", oEVENT_COUNT); end
    checks++; if (oOVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b want 0", oOVERFLOW); end
    popOne();
    checks++; if (oEVENT_COUNT !== 5'd0) begin errors++; $display("[TB] FAIL empty_pop_count: got %0d want 0", oEVENT_COUNT); end
  endtask

  task automatic test_make_pop;
    applyStimulus(8'h1C);
    checks++; if (oEVENT_VALID !== 1'b1) begin errors++; $display("[TB] FAIL make_valid: got %b want 1", oEVENT_VALID); end
    checks++; if (oEVENT_DATA !== 10'h01C) begin errors++; $display("[TB] FAIL make_data: got %h want 01c", oEVENT_DATA); end
    checks++; if (oEVENT_COUNT !== 5'd1) begin errors++; $display("[TB] FAIL make_count: got %0d want 1", oEVENT_COUNT); end
    idle(1);
    popOne();
    checks++; if (oEVENT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL make_pop_valid: got %b want 0", oEVENT_VALID); end
    checks++; if (oEVENT_DATA !== 10'h000) begin errors++; $display("[TB] FAIL make_pop_data: got %h want 000", oEVENT_DATA); end
  endtask

  task automatic test_prefixes;
    logic [7:0] seq [$];
    seq = '{8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12};
    foreach (seq[i]) begin applyStimulus(seq[i]); idle(1); end
    checks++; if (oEVENT_COUNT !== 5'd2) begin errors++; $display("[TB] FAIL prefix_count: got %0d want 2", oEVENT_COUNT); end
    checks++; if (oEVENT_DATA !== 10'h21C) begin errors++; $display("[TB] FAIL prefix_brk: got %h want 21c", oEVENT_DATA); end
    popOne();
    checks++; if (oEVENT_DATA !== 10'h375) begin errors++; $display("[TB] FAIL prefix_extbrk: got %h want 375", oEVENT_DATA); end
    popOne();
    checks++; if (oEVENT_COUNT !== 5'd0) begin errors++; $display("[TB] FAIL prefix_drain: got %0d want 0", oEVENT_COUNT); end
  endtask

  task automatic test_pause;
    logic [7:0] seq [$];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    foreach (seq[i]) applyStimulus(seq[i]);
    idle(1);
    checks++; if (oEVENT_COUNT !== 5'd1) begin errors++; $display("[TB] FAIL pause_count: got %0d want 1", oEVENT_COUNT); end
    checks++; if (oEVENT_DATA !== 10'h177) begin errors++; $display("[TB] FAIL pause_data: got %h want 177", oEVENT_DATA); end
    popOne();
    applyStimulus(8'h1C);
    checks++; if (oEVENT_DATA !== 10'h01C) begin errors++; $display("[TB] FAIL pause_after: got %h want 01c", oEVENT_DATA); end
    popOne();
  endtask

  task automatic test_timeout;
    applyStimulus(8'hE0); idle(TMO); applyStimulus(8'h1C);
    checks++; if (oEVENT_DATA !== 10'h01C) begin errors++; $display("[TB] FAIL tmo_ext_expired: got %h want 01c", oEVENT_DATA); end
    popOne();
    applyStimulus(8'hE0); idle(TMO - 2); applyStimulus(8'h1C);
    checks++; if (oEVENT_DATA !== 10'h11C) begin errors++; $display("[TB] FAIL tmo_ext_kept: got %h want 11c", oEVENT_DATA); end
    popOne();
    applyStimulus(8'hF0); idle(TMO); applyStimulus(8'h2B);
    checks++; if (oEVENT_DATA !== 10'h02B) begin errors++; $display("[TB] FAIL tmo_brk_expired: got %h want 02b", oEVENT_DATA); end
    popOne();
    applyStimulus(8'hE1); applyStimulus(8'h14); applyStimulus(8'h77);
    idle(TMO + 3); applyStimulus(8'h1C);
    checks++; if (oEVENT_DATA !== 10'h01C || oEVENT_COUNT !== 5'd1) begin
      errors++; $display("[TB] FAIL tmo_pause_expired: got %h/%0d want 01c/1", oEVENT_DATA, oEVENT_COUNT);
    end
    popOne();
  endtask

  task automatic test_overflow;
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(8'(8'h10 + i));
    idle(1);
    checks++; if (oEVENT_COUNT !== 5'd16) begin errors++; $display("[TB] FAIL ovf_count: got %0d want 16", oEVENT_COUNT); end
    checks++; if (oOVERFLOW !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b want 1", oOVERFLOW); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (oEVENT_DATA !== 10'(8'h10 + i)) begin errors++; $display("[TB] FAIL ovf_order[%0d]: got %h want %h", i, oEVENT_DATA, 10'(8'h10 + i)); end
      popOne();
    end
    checks++; if (oEVENT_COUNT !== 5'd0 || oOVERFLOW !== 1'b1) begin
      errors++; $display("[TB] FAIL ovf_sticky: got count %0d ovf %b want 0/1", oEVENT_COUNT, oOVERFLOW);
    end
    iOVERFLOW_CLEAR = 1'b1; @(negedge iCLOCK); iOVERFLOW_CLEAR = 1'b0;
    checks++; if (oOVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b want 0", oOVERFLOW); end
    for (int i = 0; i < DEPTH; i++) applyStimulus(8'(8'h30 + i));
    iEVENT_POP = 1'b1; applyStimulus(8'h50); iEVENT_POP = 1'b0;
    checks++; if (oEVENT_COUNT !== 5'd16 || oOVERFLOW !== 1'b0) begin
      errors++; $display("[TB] FAIL full_pushpop: got count %0d ovf %b want 16/0", oEVENT_COUNT, oOVERFLOW);
    end
    checks++; if (oEVENT_DATA !== 10'h031) begin errors++; $display("[TB] FAIL full_pushpop_head: got %h want 031", oEVENT_DATA); end
    iOVERFLOW_CLEAR = 1'b1; applyStimulus(8'h51); iOVERFLOW_CLEAR = 1'b0;
    checks++; if (oOVERFLOW !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_wins: got %b want 1", oOVERFLOW); end
    for (int i = 0; i < DEPTH; i++) begin
      logic [9:0] want;
      want = (i < DEPTH - 1) ? 10'(8'h31 + i) : 10'h050;
      checks++; if (oEVENT_DATA !== want) begin errors++; $display("[TB] FAIL wrap_order[%0d]: got %h want %h", i, oEVENT_DATA, want); end
      popOne();
    end
    iOVERFLOW_CLEAR = 1'b1; @(negedge iCLOCK); iOVERFLOW_CLEAR = 1'b0;
  endtask

  task automatic test_reset_midseq;
    for (int pass = 0; pass < 2; pass++) begin
      applyStimulus(8'h1C); applyStimulus(8'h1B); applyStimulus(8'h23); applyStimulus(8'hF0);
      if (pass == 0) begin
        #2 inRESET = 1'b0;
        #1;
      end else begin
        iRESET_SYNC = 1'b1; @(negedge iCLOCK);
      end
      checks++; if ({oEVENT_VALID, oEVENT_DATA, oEVENT_COUNT, oOVERFLOW} !== '0) begin
        errors++; $display("[TB] FAIL midseq_reset%0d: got v%b d%h c%0d o%b want all 0", pass, oEVENT_VALID, oEVENT_DATA, oEVENT_COUNT, oOVERFLOW);
      end
      if (pass == 0) begin
        @(negedge iCLOCK); inRESET = 1'b1; @(negedge iCLOCK);
      end else begin
        iRESET_SYNC = 1'b0;
      end
      applyStimulus(8'h1C);
      checks++; if (oEVENT_DATA !== 10'h01C || oEVENT_COUNT !== 5'd1) begin
        errors++; $display("[TB] FAIL midseq_after%0d: got %h/%0d want 01c/1", pass, oEVENT_DATA, oEVENT_COUNT);
      end
      popOne();
    end
    applyStimulus(8'hFA); applyStimulus(8'hAA); applyStimulus(8'hFE); idle(2);
    checks++; if (oEVENT_VALID !== 1'b0 || oEVENT_COUNT !== 5'd0) begin
      errors++; $display("[TB] FAIL filtered: got v%b c%0d want 0/0", oEVENT_VALID, oEVENT_COUNT);
    end
  endtask

  task automatic test_back_to_back;
    iEVENT_POP = 1'b1; applyStimulus(8'h2A); iEVENT_POP = 1'b0;
    checks++; if (oEVENT_COUNT !== 5'd1 || oEVENT_DATA !== 10'h02A) begin
      errors++; $display("[TB] FAIL empty_pushpop: got %h/%0d want 02a/1", oEVENT_DATA, oEVENT_COUNT);
    end
    popOne();
    applyStimulus(8'hE0); applyStimulus(8'h74); applyStimulus(8'hF0); applyStimulus(8'h74);
    checks++; if (oEVENT_DATA !== 10'h174 || oEVENT_COUNT !== 5'd2) begin
      errors++; $display("[TB] FAIL b2b_first: got %h/%0d want 174/2", oEVENT_DATA, oEVENT_COUNT);
    end
    popOne();
    checks++; if (oEVENT_DATA !== 10'h274) begin errors++; $display("[TB] FAIL b2b_second: got %h want 274", oEVENT_DATA); end
    popOne();
  endtask

  // Reference: each key token maps to at most one event {break, extended, code}.
  task automatic test_random;
    logic [7:0] filt [6];
    logic [9:0] expQ [$];
    logic [7:0] seq [$];
    logic [9:0] want;
    logic [7:0] c;
    int         ntok, kind;
    bit         allowFilter;
    filt = '{8'hFA, 8'hFE, 8'hAA, 8'hEE, 8'h00, 8'hFF};
    for (int batch = 0; batch < 20; batch++) begin
      ntok = $urandom_range(1, 10);
      for (int t = 0; t < ntok; t++) begin
        seq.delete();
        allowFilter = 1'b1;
        kind = $urandom_range(0, 6);
        c = 8'($urandom_range(1, 8'h83));
        if (kind == 2 || kind == 3) while (c == 8'h12 || c == 8'h59) c = 8'($urandom_range(1, 8'h83));
        case (kind)
          0: begin seq = '{c};                expQ.push_back(10'(c)); end
          1: begin seq = '{8'hF0, c};         expQ.push_back(10'd512 + 10'(c)); end
          2: begin seq = '{8'hE0, c};         expQ.push_back(10'd256 + 10'(c)); end
          3: begin seq = '{8'hE0, 8'hF0, c};  expQ.push_back(10'd768 + 10'(c)); end
          4: begin
            c = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
            if ($urandom_range(0, 1) == 0) seq = '{8'hE0, c}; else seq = '{8'hE0, 8'hF0, c};
          end
          5: begin
            seq.push_back(8'hE1);
            for (int k = 0; k < 7; k++) seq.push_back(8'($urandom_range(0, 255)));
            expQ.push_back(10'h177);
            allowFilter = 1'b0;
          end
          default: seq = '{filt[$urandom_range(0, 5)]};
        endcase
        if (allowFilter && $urandom_range(0, 3) == 0)
          seq.insert($urandom_range(0, seq.size()), filt[$urandom_range(0, 5)]);
        foreach (seq[i]) begin applyStimulus(seq[i]); idle($urandom_range(0, 2)); end
      end
      idle(2);
      checks++; if (oEVENT_COUNT !== 5'(expQ.size())) begin
        errors++; $display("[TB] FAIL rand_count[%0d]: got %0d want %0d", batch, oEVENT_COUNT, expQ.size());
      end
      while (expQ.size() > 0) begin
        want = expQ.pop_front();
        checks++; if (oEVENT_VALID !== 1'b1 || oEVENT_DATA !== want) begin
          errors++; $display("[TB] FAIL rand_event[%0d]: got v%b %h want 1 %h", batch, oEVENT_VALID, oEVENT_DATA, want);
        end
        popOne();
      end
      checks++; if (oEVENT_VALID !== 1'b0 || oOVERFLOW !== 1'b0) begin
        errors++; $display("[TB] FAIL rand_drain[%0d]: got v%b o%b want 0/0", batch, oEVENT_VALID, oOVERFLOW);
      end
    end
  endtask

  initial begin
    inRESET         = 1'b1;
    iRESET_SYNC     = 1'b0;
    iPS2MOD_REQ     = 1'b0;
    iPS2MOD_DATA    = 8'h00;
    iEVENT_POP      = 1'b0;
    iOVERFLOW_CLEAR = 1'b0;
    test_reset();
    test_make_pop();
    test_prefixes();
    test_pause();
    test_timeout();
    test_overflow();
    test_reset_midseq();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
